// File: rtl/mux4_rr_sched_if.sv
// Request/grant/select bundle between four requesters and the round-robin scheduler.
// The scheduler takes the slave side; the requester cluster takes the master side.
interface mux4_rr_sched_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel_s1;
    logic       sel_s0;
    logic       busy;

    modport master (
        output req,
        input  gnt,
        input  sel_s1,
        input  sel_s0,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel_s1,
        output sel_s0,
        output busy
    );
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux among four requesters.
// Registered one-hot grant and mux selects, with a bounded tenure per owner.
module mux4_rr_sched #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux4_rr_sched_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_MAX - 1);
    localparam logic             HAS_LIM  = (HOLD_MAX != 0);

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;

    logic             win_ptr_ok, win_nxt_ok;
    logic [1:0]       win_ptr, win_nxt;
    logic [1:0]       ptr_nxt;
    logic             own_req, others, at_lim;

    // Returns {found, index} of the first set bit scanning upward from p.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] idx;
        logic [1:0] n;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            n = p + 2'(k);
            if (!found && r[n]) begin
                found = 1'b1;
                idx   = n;
            end
        end
        return {found, idx};
    endfunction

    assign ptr_nxt = owner_q + 2'd1;
    assign {win_ptr_ok, win_ptr} = pick(bus.req, ptr_q);
    assign {win_nxt_ok, win_nxt} = pick(bus.req, ptr_nxt);
    assign own_req = bus.req[owner_q];
    assign others  = |(bus.req & ~(4'b0001 << owner_q));
    assign at_lim  = HAS_LIM && (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_ptr_ok) begin
                    state_d = GRANT;
                    owner_d = win_ptr;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    ptr_d = ptr_nxt;
                    cnt_d = '0;
                    if (win_nxt_ok) begin
                        owner_d = win_nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (at_lim) begin
                    cnt_d = '0;
                    if (others) begin
                        ptr_d   = ptr_nxt;
                        owner_d = win_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
    end

    // owner_q doubles as the select register and is left alone in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.sel_s1 = owner_q[1];
    assign bus.sel_s0 = owner_q[0];
    assign bus.busy   = |gnt_q;
endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed and random stimulus for mux4_rr_sched, checked cycle by cycle
// against a rule-level model of the round-robin scheduler.
module tb_mux4_rr_sched;
    localparam int H = 4;

    logic clk;
    logic rst;
    mux4_rr_sched_if bus ();

    mux4_rr_sched #(.HOLD_MAX(H), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    bit m_active;
    int m_owner;
    int m_ptr;
    int m_used;

    logic [7:0] din [4];
    logic [7:0] mux_out;
    logic [3:0] exp_gnt;

    assign mux_out = din[{bus.sel_s1, bus.sel_s0}];

    function automatic int search(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rs);
        int w;
        if (rs) begin
            m_active = 0;
            m_owner  = 0;
            m_ptr    = 0;
            m_used   = 0;
        end else if (!m_active) begin
            w = search(r, m_ptr);
            if (w >= 0) begin
                m_active = 1;
                m_owner  = w;
                m_used   = 1;
            end
        end else if (!r[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            w = search(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_used  = 1;
            end else begin
                m_active = 0;
            end
        end else if (m_used == H) begin
            if ((r & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = search(r, m_ptr);
            end
            m_used = 1;
        end else begin
            m_used++;
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // One clock: drive at negedge, model on the edge, sample 1 ns later.
    task automatic cyc(input logic [3:0] r, input logic rs);
        logic [1:0] osel;
        rst     = rs;
        bus.req = r;
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        @(posedge clk);
        model_step(r, rs);
        #1;
        exp_gnt = m_active ? (4'b0001 << m_owner) : 4'b0000;
        osel    = 2'(m_owner);
        chk4("gnt", bus.gnt, exp_gnt);
        chk4("sel", {2'b00, bus.sel_s1, bus.sel_s0}, {2'b00, osel});
        chk4("busy", {3'b000, bus.busy}, {3'b000, m_active});
        chk8("mux_out", mux_out, din[m_owner]);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] r;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        m_active = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_used   = 0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        @(negedge clk);

        // reset with everyone requesting, then first grant to requester 0
        cyc(4'b1111, 1'b1);
        cyc(4'b1111, 1'b1);
        chk4("reset_gnt", bus.gnt, 4'b0000);
        cyc(4'b1111, 1'b0);
        chk4("first_gnt", bus.gnt, 4'b0001);

        // single requester 2, then withdraw
        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b0);
        chk4("solo_sel", {2'b00, bus.sel_s1, bus.sel_s0}, 4'b0010);
        cyc(4'b0000, 1'b0);
        chk4("drop_gnt", bus.gnt, 4'b0000);
        chk4("idle_sel", {2'b00, bus.sel_s1, bus.sel_s0}, 4'b0010);

        // fairness: all four continuously for two rotations
        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 4 * H * 2; i++) cyc(4'b1111, 1'b0);
        chk4("rot_gnt", bus.gnt, 4'b1000);

        // hand-off without bubble, then wrap past owner 3
        cyc(4'b0000, 1'b1);
        cyc(4'b0010, 1'b0);
        cyc(4'b1010, 1'b0);
        cyc(4'b1000, 1'b0);
        chk4("handoff", bus.gnt, 4'b1000);
        cyc(4'b0011, 1'b0);
        chk4("wrap", bus.gnt, 4'b0001);

        // lone requester renews through timeouts
        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 12; i++) cyc(4'b0001, 1'b0);
        chk4("renew", bus.gnt, 4'b0001);

        // reset mid-tenure
        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b1);
        chk4("mid_rst", bus.gnt, 4'b0000);
        cyc(4'b1111, 1'b0);
        chk4("post_rst", bus.gnt, 4'b0001);

        // random traffic with sticky-ish requests and rare resets
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            cyc(r, ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
